// File: rtl/dvs_fir_if.sv
// Sample-stream bundle for the dvs_fir filter: input sample, mode select and
// registered filtered output.
interface dvs_fir_if #(
   parameter int DATA_W = 16
);
   logic signed [DATA_W-1:0] data_in;
   logic                     low_power_mode;
   logic signed [DATA_W-1:0] filtered_data;

   modport master (
      output data_in,
      output low_power_mode,
      input  filtered_data
   );

   modport slave (
      input  data_in,
      input  low_power_mode,
      output filtered_data
   );
endinterface

// File: rtl/dvs_fir.sv
// Fixed-coefficient symmetric low-pass FIR with a reduced-tap power-saving mode
// that freezes the upper delay line and gates the upper multipliers.
module dvs_fir #(
   parameter int TAPS   = 8,
   parameter int DATA_W = 16,
   parameter int COEF_W = 16
) (
   input logic      clk,
   input logic      reset,
   dvs_fir_if.slave bus
);

   localparam int HALF   = TAPS / 2;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(TAPS);

   // Symmetric Q1.15 taps doubling toward the centre: 1024, 2048, 4096, 8192, ...
   function automatic logic signed [COEF_W-1:0] coef(input int k);
      int d;
      d = (k < TAPS - 1 - k) ? k : TAPS - 1 - k;
      return COEF_W'(1024 << d);
   endfunction

   logic signed [DATA_W-1:0] x    [TAPS];
   logic signed [DATA_W-1:0] s    [TAPS];
   logic signed [DATA_W-1:0] op   [TAPS];
   logic signed [PROD_W-1:0] prod [TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] result;
   logic                     unused_acc_bits;

   assign s[0] = bus.data_in;
   for (genvar k = 1; k < TAPS; k++) begin : g_sample
      assign s[k] = x[k-1];
   end

   // Upper-half operands are forced to zero in low-power mode so those
   // multipliers stop toggling.
   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) begin
         op[k]   = (bus.low_power_mode && k >= HALF) ? '0 : s[k];
         prod[k] = op[k] * coef(k);
         acc     = acc + ACC_W'(prod[k]);
      end
   end

   // Slicing the accumulator is the arithmetic shift plus truncation; the
   // half-tap sum uses one less bit of shift to keep the DC gain near unity.
   always_comb begin
      result = bus.low_power_mode ? acc[COEF_W-2 +: DATA_W] : acc[COEF_W-1 +: DATA_W];
   end

   assign unused_acc_bits = ^{acc[ACC_W-1:PROD_W-1], acc[COEF_W-3:0]};

   // Taps at and above HALF-1 hold in low-power mode; the stale history is
   // deliberately kept so normal mode resumes from it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < TAPS; k++) begin
            x[k] <= '0;
         end
         bus.filtered_data <= '0;
      end else begin
         x[0] <= bus.data_in;
         for (int k = 1; k < TAPS; k++) begin
            if (!(bus.low_power_mode && k >= HALF - 1)) begin
               x[k] <= x[k-1];
            end
         end
         bus.filtered_data <= result;
      end
   end

endmodule

// File: tb/tb_dvs_fir.sv
// Self-checking bench for dvs_fir: hand-computed vector table plus modelled
// sequences for reset, low-power freeze and mixed-mode streaming.
module tb_dvs_fir;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   dvs_fir_if #(.DATA_W(16)) bus ();

   dvs_fir #(.TAPS(8), .DATA_W(16), .COEF_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit                 rst_before;
      logic signed [15:0] din;
      logic               lp;
      logic signed [15:0] exp_out;
      string              tag;
   } vec_t;

   vec_t vecs[$];

   int                 h [8] = '{1024, 2048, 4096, 8192, 8192, 4096, 2048, 1024};
   logic signed [15:0] m_x [8];

   function automatic void add_vec(input bit rst_before, input logic signed [15:0] din,
                                   input logic lp, input logic signed [15:0] exp_out,
                                   input string tag);
      vec_t v;
      v.rst_before = rst_before;
      v.din        = din;
      v.lp         = lp;
      v.exp_out    = exp_out;
      v.tag        = tag;
      vecs.push_back(v);
   endfunction

   // Reference filter written straight from the tap equations.
   task automatic model_step(input logic signed [15:0] din, input logic lp,
                             output logic signed [15:0] exp_out);
      longint             acc;
      longint             shifted;
      logic signed [15:0] smp;
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         smp = (k == 0) ? din : m_x[k-1];
         if (!(lp && k >= 4)) acc += longint'(h[k]) * longint'(smp);
      end
      shifted = lp ? (acc >>> 14) : (acc >>> 15);
      exp_out = shifted[15:0];
      for (int k = 7; k >= 1; k--) begin
         if (!(lp && k >= 3)) m_x[k] = m_x[k-1];
      end
      m_x[0] = din;
   endtask

   task automatic check_output(input string name, input logic signed [15:0] actual,
                               input logic signed [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input logic signed [15:0] din, input logic lp,
                                 output logic signed [15:0] model_exp);
      bus.data_in        = din;
      bus.low_power_mode = lp;
      model_step(din, lp, model_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.data_in        = '0;
      bus.low_power_mode = 1'b0;
      reset              = 1'b0;
      for (int k = 0; k < 8; k++) m_x[k] = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      logic signed [15:0] mexp;
      logic signed [15:0] imp_n [9] = '{512, 1024, 2048, 4096, 4096, 2048, 1024, 512, 0};
      int                 cum   [8] = '{1024, 3072, 7168, 15360, 23552, 27648, 29696, 30720};
      logic signed [15:0] imp_l [5] = '{1024, 2048, 4096, 8192, 0};
      logic signed [15:0] mix_d [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
                                         16'hABCD, 16'h1234, 16'h9876, 16'h5432};
      logic               mix_l [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.data_in        = '0;
      bus.low_power_mode = 1'b0;
      for (int k = 0; k < 8; k++) m_x[k] = '0;
      #1;
      check_output("reset_state", bus.filtered_data, 16'sd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 9; i++)
         add_vec(i == 0, (i == 0) ? 16'sd16384 : 16'sd0, 1'b0, imp_n[i], $sformatf("impulse_n[%0d]", i));
      for (int i = 0; i < 8; i++)
         add_vec(i == 0, 16'sd32767, 1'b0, 16'(cum[i] - 1), $sformatf("dc_pos[%0d]", i));
      for (int i = 0; i < 8; i++)
         add_vec(i == 0, -16'sd32768, 1'b0, 16'(-cum[i]), $sformatf("dc_neg[%0d]", i));
      for (int i = 0; i < 9; i++)
         add_vec(i == 0, (i == 0) ? -16'sd1 : 16'sd0, 1'b0, (i < 8) ? -16'sd1 : 16'sd0,
                 $sformatf("neg_one[%0d]", i));
      for (int i = 0; i < 5; i++)
         add_vec(i == 0, (i == 0) ? 16'sd16384 : 16'sd0, 1'b1, imp_l[i], $sformatf("impulse_lp[%0d]", i));

      foreach (vecs[i]) begin
         if (vecs[i].rst_before) do_reset();
         apply_stimulus(vecs[i].din, vecs[i].lp, mexp);
         check_output(vecs[i].tag, bus.filtered_data, vecs[i].exp_out);
      end

      // Asynchronous reset asserted mid-cycle, then held across an edge.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(16'h1234, 1'b0, mexp);
         check_output($sformatf("pre_reset[%0d]", i), bus.filtered_data, mexp);
      end
      #3;
      reset = 1'b0;
      #1;
      check_output("async_reset", bus.filtered_data, 16'sd0);
      @(posedge clk);
      #1;
      check_output("reset_hold", bus.filtered_data, 16'sd0);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) m_x[k] = '0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(16'sd0, 1'b0, mexp);
         check_output($sformatf("post_reset[%0d]", i), bus.filtered_data, 16'sd0);
      end

      // Fill, freeze the upper taps in low power, then resume from held values.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(16'h5678, 1'b0, mexp);
         check_output($sformatf("fill[%0d]", i), bus.filtered_data, mexp);
      end
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(16'hABCD, 1'b1, mexp);
         check_output($sformatf("freeze_lp[%0d]", i), bus.filtered_data, mexp);
      end
      apply_stimulus(16'hABCD, 1'b0, mexp);
      check_output("resume_hand", bus.filtered_data, 16'sd272);
      check_output("resume_model", bus.filtered_data, mexp);
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(16'sd0, 1'b0, mexp);
         check_output($sformatf("resume_tail[%0d]", i), bus.filtered_data, mexp);
      end

      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(mix_d[i], mix_l[i], mexp);
         check_output($sformatf("mixed[%0d]", i), bus.filtered_data, mexp);
      end
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(16'sd0, 1'b0, mexp);
         check_output($sformatf("mixed_tail[%0d]", i), bus.filtered_data, mexp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
